// File: rtl/iir_sample_sink_if.sv
// Sample stream bundle between iir_filter output, the sink FIFO and its downstream consumer.
// master drives the valid-only input stream and the consumer ready; slave is the sink.
interface iir_sample_sink_if #(
    parameter int NB = 12
);
    logic          vIn;
    logic [NB-1:0] dIn;
    logic          rdy;
    logic          vOut;
    logic [NB-1:0] dOut;

    modport master (output vIn, dIn, rdy, input vOut, dOut);
    modport slave  (input vIn, dIn, rdy, output vOut, dOut);
endinterface

// File: rtl/iir_sample_sink.sv
// First-word-fall-through sample FIFO after iir_filter: valid-only input, valid/ready output,
// accepted-sample counter and sticky overflow. Define IIR_SINK_MINMAX_EN for signed smin/smax tracking.
module iir_sample_sink #(
    parameter int NB    = 12,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    iir_sample_sink_if.slave         bus,
    input  logic                     clr,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         cnt,
    output logic                     ovf
`ifdef IIR_SINK_MINMAX_EN
    ,
    output logic [NB-1:0]            smin,
    output logic [NB-1:0]            smax
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [NB-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [NB-1:0] dout_q;
    logic [NB-1:0] dout_next;
    logic [AW-1:0] rd_next_idx;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;

    // The extra pointer bit distinguishes full from empty when the low bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

    assign pop  = bus.vOut && bus.rdy;
    assign push = bus.vIn && (!full || pop);
    assign drop = bus.vIn && full && !pop;

    assign bus.vOut = !empty;
    assign bus.dOut = dout_q;

    assign rd_next_idx = rd_ptr[AW-1:0] + 1'b1;

    // Next head of FIFO: the new sample when it lands in an empty FIFO (or replaces the
    // last entry being popped), otherwise the entry behind the current head.
    always_comb begin
        // NOTE: default assignment first so no path leaves dout_next unassigned (no latch).
        dout_next = dout_q;
        if (push && empty) begin
            dout_next = bus.dIn;
        end else if (pop) begin
            if (level > PW'(1)) begin
                dout_next = mem[rd_next_idx];
            end else if (push) begin
                dout_next = bus.dIn;
            end
        end
    end

    // NOTE: storage has no reset; its contents are only read behind a valid pointer range.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= bus.dIn;
        end
    end

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout_q <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else if (clr) begin
            // Clear wins over a same-cycle push or pop; that sample is neither stored nor counted.
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                cnt    <= cnt + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                ovf <= 1'b1;
            end
            dout_q <= dout_next;
        end
    end

`ifdef IIR_SINK_MINMAX_EN
    localparam logic [NB-1:0] MOST_POS = {1'b0, {(NB-1){1'b1}}};
    localparam logic [NB-1:0] MOST_NEG = {1'b1, {(NB-1){1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smin <= MOST_POS;
            smax <= MOST_NEG;
        end else if (clr) begin
            smin <= MOST_POS;
            smax <= MOST_NEG;
        end else if (push) begin
            if ($signed(bus.dIn) < $signed(smin)) begin
                smin <= bus.dIn;
            end
            if ($signed(bus.dIn) > $signed(smax)) begin
                smax <= bus.dIn;
            end
        end
    end
`endif

endmodule

// File: tb/tb_iir_sample_sink.sv
// Self-checking bench for iir_sample_sink: queue scoreboard of expected output samples,
// directed steps driven on the falling edge, outputs compared before each rising edge.
module tb_iir_sample_sink;
    localparam int NB    = 12;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam logic [NB-1:0] MOST_POS = 12'h7FF;
    localparam logic [NB-1:0] MOST_NEG = 12'h800;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic [LW-1:0] level;
    logic [CNT_W-1:0] cnt;
    logic          ovf;
`ifdef IIR_SINK_MINMAX_EN
    logic [NB-1:0] smin;
    logic [NB-1:0] smax;
`endif

    iir_sample_sink_if #(.NB(NB)) bus ();

    iir_sample_sink #(.NB(NB), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .clr   (clr),
        .level (level),
        .cnt   (cnt),
        .ovf   (ovf)
`ifdef IIR_SINK_MINMAX_EN
        ,
        .smin  (smin),
        .smax  (smax)
`endif
    );

    always #5 clk = ~clk;

    logic [NB-1:0]        exp_q[$];
    int                   m_cnt;
    bit                   m_ovf;
    logic signed [NB-1:0] m_min;
    logic signed [NB-1:0] m_max;
    int                   errors;
    int                   checks;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        m_min = MOST_POS;
        m_max = MOST_NEG;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".vOut"}, {31'd0, bus.vOut}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            check({tag, ".dOut"}, {20'd0, bus.dOut}, {20'd0, exp_q[0]});
        end
        check({tag, ".level"}, {28'd0, level}, exp_q.size());
        check({tag, ".cnt"}, {16'd0, cnt}, m_cnt);
        check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, m_ovf});
`ifdef IIR_SINK_MINMAX_EN
        check({tag, ".smin"}, {20'd0, smin}, {20'd0, m_min});
        check({tag, ".smax"}, {20'd0, smax}, {20'd0, m_max});
`endif
    endtask

    // One clock cycle: drive inputs, compare current outputs, advance the model, clock.
    task automatic step(input string tag, input bit v, input logic [NB-1:0] d,
                        input bit r, input bit c);
        bit pop;
        bit full;
        bus.vIn = v;
        bus.dIn = d;
        bus.rdy = r;
        clr     = c;
        check_outputs(tag);
        pop  = r && (exp_q.size() != 0);
        full = (exp_q.size() == DEPTH);
        if (c) begin
            model_clear();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (v) begin
                if (!full || pop) begin
                    exp_q.push_back(d);
                    m_cnt = (m_cnt + 1) % (1 << CNT_W);
                    if ($signed(d) < m_min) m_min = d;
                    if ($signed(d) > m_max) m_max = d;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".vOut"}, {31'd0, bus.vOut}, 32'd0);
        check({tag, ".dOut"}, {20'd0, bus.dOut}, 32'd0);
        check({tag, ".level"}, {28'd0, level}, 32'd0);
        check({tag, ".cnt"}, {16'd0, cnt}, 32'd0);
        check({tag, ".ovf"}, {31'd0, ovf}, 32'd0);
`ifdef IIR_SINK_MINMAX_EN
        check({tag, ".smin"}, {20'd0, smin}, {20'd0, MOST_POS});
        check({tag, ".smax"}, {20'd0, smax}, {20'd0, MOST_NEG});
`endif
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        bus.vIn = 1'b0;
        bus.dIn = '0;
        bus.rdy = 1'b0;
        model_clear();

        // Reset state
        #2;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        // Reset then stream 1..5 with rdy high
        for (int i = 1; i <= 5; i++) step("stream", 1'b1, NB'(i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("stream_drain", 1'b0, '0, 1'b1, 1'b0);

        // Backpressure fill: 10 pushes into a depth-8 FIFO, last two dropped
        step("bp_clr", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step("bp_fill", 1'b1, NB'(12'h010 + i), 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step("bp_drain", 1'b0, '0, 1'b1, 1'b0);

        // Full FIFO with simultaneous push and pop
        step("fp_clr", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step("fp_fill", 1'b1, NB'(12'h100 + i), 1'b0, 1'b0);
        step("fp_both", 1'b1, 12'hABC, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step("fp_drain", 1'b0, '0, 1'b1, 1'b0);

        // Stall hold: head stays put while rdy is low
        step("st_clr", 1'b0, '0, 1'b0, 1'b1);
        step("st_head", 1'b1, 12'h7FF, 1'b0, 1'b0);
        step("st_push", 1'b1, 12'h800, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("st_hold", 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("st_drain", 1'b0, '0, 1'b1, 1'b0);

        // clr priority over push and pop with level=3 and ovf set
        step("cp_clr0", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step("cp_fill", 1'b1, NB'(12'h200 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("cp_pop", 1'b0, '0, 1'b1, 1'b0);
        step("cp_at3", 1'b1, 12'h123, 1'b1, 1'b1);
        step("cp_after", 1'b0, '0, 1'b1, 1'b0);
        step("cp_idle", 1'b0, '0, 1'b1, 1'b0);

        // Signed min/max tracking, then async reset between edges with samples in flight
        step("mm_0", 1'b1, 12'h005, 1'b0, 1'b0);
        step("mm_1", 1'b1, 12'hFF0, 1'b0, 1'b0);
        step("mm_2", 1'b1, 12'h300, 1'b0, 1'b0);
        bus.vIn = 1'b0;
        check_outputs("mm_final");
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 1'b1, 12'h055, 1'b1, 1'b0);
        step("post_rst_out", 1'b0, '0, 1'b1, 1'b0);
        step("post_rst_idle", 1'b0, '0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iir_sample_sink.md
Name: iir_sample_sink

Overview:
- Receiving end of the filter output stream. Consumes the filter's valid-only sample interface (vIn/dIn, no backpressure) and buffers samples in a small FIFO.
- Re-presents samples to a downstream consumer over a valid/ready handshake.
- Tracks accepted-sample count and sticky overflow status.
- Sits directly after iir_filter in the datapath, replacing the bench-only data sink in synthesizable builds.

Parameters:
- NB, 12, sample width in bits (two's complement), equal to the filter's NB
- DEPTH, 8, FIFO depth in samples; power of two, minimum 2
- CNT_W, 16, width of the accepted-sample counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- vIn  in  1  input sample valid, one sample per cycle when high
- dIn  in  NB  input sample
- clr  in  1  synchronous clear: flushes FIFO, zeroes counter, clears ovf
- rdy  in  1  downstream ready
- vOut  out  1  output sample valid
- dOut  out  NB  output sample (head of FIFO)
- level  out  log2(DEPTH)+1  current FIFO occupancy
- cnt  out  CNT_W  number of samples accepted into FIFO
- ovf  out  1  sticky: a sample was dropped because the FIFO was full

Behaviour:
- Reset (async, rst=1): pointers=0, level=0, vOut=0, dOut=0, cnt=0, ovf=0. Storage contents are don't-care.
- Reset asserted mid-stream: the FIFO empties immediately, and in-flight samples are lost without setting ovf.
- Storage: DEPTH x NB array with wr_ptr and rd_ptr of log2(DEPTH)+1 bits (extra wrap bit).
  - empty = pointers equal.
  - full = low bits equal and wrap bits differ.
  - Pointers wrap modulo 2*DEPTH with no special case.
- Push occurs at a rising edge when vIn=1 and (not full, or pop in the same cycle).
- Pop occurs at a rising edge when vOut=1 and rdy=1.
- Simultaneous push and pop: both happen, and level is unchanged.
  - Holds when full: the push succeeds because the head leaves.
  - Holds when empty: no pop is possible, so the push only is performed.
- Dropped sample: vIn=1, full, and no pop. The sample is discarded, ovf is set to 1 at that edge, and cnt is not incremented.
- Latency and output timing:
  - First-word-fall-through.
  - A sample pushed into an empty FIFO at edge k is presented on vOut/dOut from edge k (i.e. in the cycle after vIn was high).
  - dOut is registered, updated on push-into-empty or pop.
  - dOut holds its value while vOut=1 and rdy=0.
  - Sample order is strictly preserved.
- vOut = (level != 0), registered-equivalent.
  - Once high, vOut never drops without a pop, clr, or rst.
- cnt increments by 1 per push and wraps from 2^CNT_W-1 to 0 silently.
- clr=1 at an edge sets pointers, level, and cnt to 0, ovf to 0, and vOut to 0.
  - clr has priority over push and pop in the same cycle; that sample is discarded and not counted.
- dIn is ignored when vIn=0. rdy is ignored when vOut=0.

Optional Feature:
- Macro: IIR_SINK_MINMAX_EN
- Defined: adds ports smin (out NB) and smax (out NB).
  - Signed running minimum and maximum of all pushed samples since reset or clr.
  - Reset/clr values: smin = most positive NB-bit value, smax = most negative NB-bit value.
  - Updated on the same edge as the push; dropped samples are excluded.
- Undefined: the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- Reset then stream: rst pulse, then vIn=1 for 5 cycles with dIn=1,2,3,4,5 and rdy=1 -> vOut high from the cycle after the first vIn; dOut=1..5 in order; cnt=5; level returns to 0; ovf=0.
- Backpressure fill: rdy=0, DEPTH=8, push 10 samples 0x010..0x019 -> level=8, cnt=8, ovf=1 after the 9th push. Then rdy=1 -> dOut=0x010..0x017; the last two samples are never output.
- Full with simultaneous pop: FIFO full, vIn=1 with dIn=0xABC and rdy=1 in the same cycle -> level stays 8, ovf stays 0, cnt increments, and 0xABC emerges last.
- Stall hold: vOut=1, dOut=0x7FF, rdy=0 for 4 cycles while pushing 0x800 -> dOut stays 0x7FF; then 0x800 follows once rdy=1.
- clr priority: level=3, ovf=1, then clr=1 with vIn=1 and rdy=1 in the same cycle -> next cycle level=0, vOut=0, cnt=0, ovf=0, and no sample is output.
- Async reset mid-operation plus optional feature: with IIR_SINK_MINMAX_EN, push 0x005, 0xFF0, 0x300 -> smin=0xFF0 (-16), smax=0x300. Then assert rst between clock edges -> all outputs return to reset values immediately, without waiting for a clock edge.
